stack_unit: RTL and testbench

Hardware operand stack (LIFO) consumed by the stack-based multi-cycle MIPS datapath.
- Takes Push/Pop strobes from the controller and a write value selected by the datapath's MtoS mux.
- Drives toS and next-on-stack values back into the A/B operand registers.
- Provides occupancy, full/empty status and sticky overflow/underflow error flags for debug and testbench checking.

---
 rtl/stack_unit.sv | 104 ++++++++++
 tb/tb_stack_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Hardware operand stack (LIFO) feeding the A/B operand registers of the stack-based MIPS datapath.
// tos/nos/empty/full are combinational from registered state; ovf/unf are sticky error flags.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [PTR_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int IDX_W = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic              r_ovf;
  logic              r_unf;

  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_nos_idx;
  logic              w_we;
  logic [IDX_W-1:0]  w_widx;
  logic [PTR_W-1:0]  w_sp_nxt;
  logic              w_ovf_ev;
  logic              w_unf_ev;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == PTR_W'(DEPTH));
  assign w_top_idx = IDX_W'(r_sp - PTR_W'(1));
  assign w_nos_idx = IDX_W'(r_sp - PTR_W'(2));

  // Invalid slots read as zero so A/B never load X during bring-up
  assign tos   = w_empty ? '0 : r_mem[w_top_idx];
  assign nos   = (r_sp < PTR_W'(2)) ? '0 : r_mem[w_nos_idx];
  assign count = r_sp;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

  always_comb begin
    w_we     = 1'b0;
    w_widx   = r_sp[IDX_W-1:0];
    w_sp_nxt = r_sp;
    w_ovf_ev = 1'b0;
    w_unf_ev = 1'b0;
    if (push && pop) begin
      // Replace-top; on an empty stack the pop half is rejected and the push lands at index 0
      w_we = 1'b1;
      if (w_empty) begin
        w_unf_ev = 1'b1;
        w_sp_nxt = PTR_W'(1);
      end else begin
        w_widx = w_top_idx;
      end
    end else if (push) begin
      if (w_full) begin
        w_ovf_ev = 1'b1;
      end else begin
        w_we     = 1'b1;
        w_sp_nxt = r_sp + PTR_W'(1);
      end
    end else if (pop) begin
      if (w_empty) begin
        w_unf_ev = 1'b1;
      end else begin
        w_sp_nxt = r_sp - PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[w_widx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      // A fresh error event outranks a simultaneous clear
      r_ovf <= w_ovf_ev | (r_ovf & ~clr_err);
      r_unf <= w_unf_ev | (r_unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed vector table, a fill/overflow sequence, and random traffic
// checked against a queue-based LIFO model.
module tb_stack_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] tos;
  logic [DW-1:0] nos;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  stack_unit #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain LIFO queue plus two sticky bits
  logic [DW-1:0] m_q [$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  typedef struct {
    logic          r, pu, po;
    logic [DW-1:0] d;
    logic          c;
    logic [DW-1:0] e_tos, e_nos;
    logic [PW-1:0] e_cnt;
    logic          e_emp, e_full, e_ovf, e_unf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic pu, input logic po,
                            input logic [DW-1:0] d, input logic c);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (pu && po) begin
        if (m_q.size() == 0) begin
          ue = 1'b1;
          m_q.push_back(d);
        end else begin
          m_q[m_q.size()-1] = d;
        end
      end else if (pu) begin
        if (m_q.size() == DEPTH) oe = 1'b1;
        else m_q.push_back(d);
      end else if (po) begin
        if (m_q.size() == 0) ue = 1'b1;
        else void'(m_q.pop_back());
      end
      m_ovf = oe | (m_ovf & ~c);
      m_unf = ue | (m_unf & ~c);
    end
  endtask

  // Apply one cycle of inputs, clock it, update model, sample outputs 1 ns after the edge
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [DW-1:0] d, input logic c);
    rst = r; push = pu; pop = po; din = d; clr_err = c;
    @(posedge clk);
    #1;
    model_step(r, pu, po, d, c);
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".tos"},   tos,   (n > 0) ? m_q[n-1] : 0);
    chk({tag, ".nos"},   nos,   (n > 1) ? m_q[n-2] : 0);
    chk({tag, ".count"}, count, n);
    chk({tag, ".empty"}, empty, (n == 0) ? 1 : 0);
    chk({tag, ".full"},  full,  (n == DEPTH) ? 1 : 0);
    chk({tag, ".ovf"},   ovf,   m_ovf);
    chk({tag, ".unf"},   unf,   m_unf);
  endtask

  vec_t vt [$];

  function automatic vec_t mk(logic r, logic pu, logic po, logic [DW-1:0] d, logic c,
                              logic [DW-1:0] et, logic [DW-1:0] en, logic [PW-1:0] ec,
                              logic ee, logic ef, logic eo, logic eu);
    vec_t v;
    v.r = r; v.pu = pu; v.po = po; v.d = d; v.c = c;
    v.e_tos = et; v.e_nos = en; v.e_cnt = ec;
    v.e_emp = ee; v.e_full = ef; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  initial begin
    //             r  pu po din    clr  tos    nos    cnt emp ful ovf unf
    vt.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h11, 0, 8'h11, 8'h00, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h22, 0, 8'h22, 8'h11, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h33, 0, 8'h33, 8'h22, 3, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h22, 8'h11, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h11, 8'h00, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h05, 0, 8'h05, 8'h00, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h07, 0, 8'h07, 8'h05, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 8'h09, 0, 8'h09, 8'h05, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h05, 8'h00, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 8'h44, 0, 8'h44, 8'h00, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h01, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h02, 0, 8'h02, 8'h01, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h03, 0, 8'h03, 8'h02, 3, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h01, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;

    foreach (vt[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vt[i].r, vt[i].pu, vt[i].po, vt[i].d, vt[i].c);
      chk({t, ".tos"},   tos,   vt[i].e_tos);
      chk({t, ".nos"},   nos,   vt[i].e_nos);
      chk({t, ".count"}, count, vt[i].e_cnt);
      chk({t, ".empty"}, empty, vt[i].e_emp);
      chk({t, ".full"},  full,  vt[i].e_full);
      chk({t, ".ovf"},   ovf,   vt[i].e_ovf);
      chk({t, ".unf"},   unf,   vt[i].e_unf);
    end

    // Fill to DEPTH, overflow, clear, then replace-top while full
    step(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 1, 0, DW'(k), 0);
    chk("fill.full", full, 1);
    chk("fill.tos", tos, 8'h0F);
    chk("fill.nos", nos, 8'h0E);
    step(0, 1, 0, 8'hAA, 0);
    chk("ovf.flag", ovf, 1);
    chk("ovf.tos", tos, 8'h0F);
    chk("ovf.count", count, DEPTH);
    step(0, 0, 0, 8'h00, 1);
    chk("ovf.clr", ovf, 0);
    step(0, 1, 1, 8'h55, 0);
    chk("rep_full.tos", tos, 8'h55);
    chk("rep_full.count", count, DEPTH);
    chk("rep_full.ovf", ovf, 0);
    chk_model("rep_full");
    // Overflow and clear arriving together: the new event must win
    step(0, 1, 0, 8'hBB, 1);
    chk("ovf_vs_clr", ovf, 1);
    for (int k = 0; k < DEPTH + 1; k++) step(0, 0, 1, 8'h00, 0);
    chk("both.ovf", ovf, 1);
    chk("both.unf", unf, 1);
    step(0, 0, 0, 8'h00, 1);
    chk("both_clr.ovf", ovf, 0);
    chk("both_clr.unf", unf, 0);

    // Randomized traffic with shifting push/pop bias so both full and empty are reached
    step(1, 0, 0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      int bias, rp, rq;
      logic r, pu, po, c;
      case ((n / 80) % 3)
        0: bias = 75;
        1: bias = 25;
        default: bias = 50;
      endcase
      rp = int'($urandom_range(99));
      rq = int'($urandom_range(99));
      pu = (rp < bias);
      po = (rq >= bias);
      if ($urandom_range(9) == 0) begin
        pu = 1'b1;
        po = 1'b1;
      end
      c = ($urandom_range(15) == 0);
      r = ($urandom_range(499) == 0);
      step(r, pu, po, DW'($urandom), c);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
